hkspi_responder: RTL

//  SPI responder (slave) for the housekeeping SPI on mprj_io[4:1] (SCK, CSB, SDI, SDO). Mode 0, MSB first.

---
 rtl/hkspi_pkg.sv | 27 ++
 rtl/hkspi_sync_edge.sv | 32 +++
 rtl/hkspi_responder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/hkspi_pkg.sv
// Shared types and command-field constants for the housekeeping SPI responder.
package hkspi_pkg;

    typedef enum logic [2:0] {
        WAIT_CSB,
        IDLE,
        CMD,
        ADDR,
        DATA,
        IGNORE
    } hk_state_t;

    localparam logic [1:0] CMD_WR = 2'b10;
    localparam logic [1:0] CMD_RD = 2'b01;
    localparam logic [1:0] CMD_RW = 2'b11;
    localparam int         N_MSB  = 5;
    localparam int         N_LSB  = 3;

    // A command is legal only with its low three bits clear and a known opcode.
    function automatic logic cmd_is_valid(input logic [7:0] cmd, input logic rw_en);
        logic [1:0] op;
        op = cmd[7:6];
        return (cmd[2:0] == 3'b000) &&
               ((op == CMD_WR) || (op == CMD_RD) || (rw_en && (op == CMD_RW)));
    endfunction

endpackage

// File: rtl/hkspi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with rise/fall pulses
// derived from the synchronized level.
module hkspi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Resetting to 0 means a chip select held low across reset never looks idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign dout = sync_q[SYNC_STAGES-1];
    assign rise = dout & ~prev_q;
    assign fall = ~dout & prev_q;

endmodule

// File: rtl/hkspi_responder.sv
// Housekeeping SPI responder: decodes command/address/data bytes from a mode-0
// SPI host and drives a byte-wide register-file port.
module hkspi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter bit RW_EN       = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       SCK,
    input  logic       CSB,
    input  logic       SDI,
    output logic       SDO,
    output logic       sdo_enb,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata
);
    import hkspi_pkg::*;

    logic sck_level_unused, sck_rise, sck_fall;
    logic csb_s, csb_rise, csb_fall;
    logic sdi_s, sdi_rise_unused, sdi_fall_unused;

    hk_state_t  state, state_next;
    logic [2:0] bit_cnt;
    logic [6:0] rx_sr;
    logic [7:0] tx_sr;
    logic [7:0] rx_byte;
    logic       last_bit;
    logic       wr_mode, rd_mode, stream;
    logic [2:0] bytes_left;
    logic       inc_pend, more_pend, load_tx;

    hkspi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
        .clock(clock), .reset(reset), .din(SCK),
        .dout(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
    );
    hkspi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_csb (
        .clock(clock), .reset(reset), .din(CSB),
        .dout(csb_s), .rise(csb_rise), .fall(csb_fall)
    );
    hkspi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sdi (
        .clock(clock), .reset(reset), .din(SDI),
        .dout(sdi_s), .rise(sdi_rise_unused), .fall(sdi_fall_unused)
    );

    assign rx_byte  = {rx_sr, sdi_s};
    assign last_bit = sck_rise && (bit_cnt == 3'd7);

    always_ff @(posedge clock) begin
        if (reset) state <= WAIT_CSB;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_CSB: if (csb_s) state_next = IDLE;
            IDLE:     if (csb_fall) state_next = CMD;
            CMD:      if (last_bit) state_next = cmd_is_valid(rx_byte, RW_EN) ? ADDR : IGNORE;
            ADDR:     if (last_bit) state_next = DATA;
            DATA:     if (last_bit && !stream && (bytes_left == 3'd1)) state_next = IGNORE;
            IGNORE:   state_next = IGNORE;
            default:  state_next = WAIT_CSB;
        endcase
        if (csb_rise) state_next = IDLE;
    end

    // Per-byte strobes are staggered: write at the old address, then increment
    // and read-ahead at the new one, then capture read data a cycle later.
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt    <= 3'd0;
            rx_sr      <= 7'd0;
            tx_sr      <= 8'd0;
            wr_mode    <= 1'b0;
            rd_mode    <= 1'b0;
            stream     <= 1'b0;
            bytes_left <= 3'd0;
            inc_pend   <= 1'b0;
            more_pend  <= 1'b0;
            load_tx    <= 1'b0;
            reg_addr   <= 8'd0;
            reg_wdata  <= 8'd0;
            reg_we     <= 1'b0;
            reg_re     <= 1'b0;
            SDO        <= 1'b0;
            sdo_enb    <= 1'b1;
        end else begin
            reg_we   <= 1'b0;
            reg_re   <= 1'b0;
            inc_pend <= 1'b0;
            load_tx  <= reg_re;

            if (inc_pend) begin
                reg_addr <= reg_addr + 8'd1;
                reg_re   <= rd_mode && more_pend;
            end

            case (state)
                IDLE: begin
                    sdo_enb <= 1'b1;
                    if (csb_fall) bit_cnt <= 3'd0;
                end
                CMD: begin
                    if (sck_rise) begin
                        rx_sr   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    if (last_bit) begin
                        wr_mode    <= rx_byte[7];
                        rd_mode    <= rx_byte[6];
                        stream     <= (rx_byte[N_MSB:N_LSB] == 3'd0);
                        bytes_left <= rx_byte[N_MSB:N_LSB];
                    end
                end
                ADDR: begin
                    if (sck_rise) begin
                        rx_sr   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    if (sck_fall && rd_mode) sdo_enb <= 1'b0;
                    if (last_bit) begin
                        reg_addr <= rx_byte;
                        reg_re   <= rd_mode;
                    end
                end
                DATA: begin
                    if (sck_rise) begin
                        rx_sr   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    if (sck_fall) begin
                        SDO   <= tx_sr[7];
                        tx_sr <= {tx_sr[6:0], 1'b0};
                        if (rd_mode) sdo_enb <= 1'b0;
                    end
                    if (last_bit) begin
                        if (wr_mode) begin
                            reg_we    <= 1'b1;
                            reg_wdata <= rx_byte;
                        end
                        inc_pend  <= 1'b1;
                        more_pend <= stream || (bytes_left != 3'd1);
                        if (!stream) bytes_left <= bytes_left - 3'd1;
                    end
                end
                default: sdo_enb <= 1'b1;
            endcase

            if (load_tx)  tx_sr   <= reg_rdata;
            if (csb_rise) sdo_enb <= 1'b1;
        end
    end

endmodule
